// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared timekeeping constants, widths and BCD split helper
package clock_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;
  localparam int SEC_PER_MIN   = 60;
  localparam int HALF_DAY      = 12;

  localparam int HOUR_W   = 5;
  localparam int MINSEC_W = 6;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic bcd_t bcd_split(input logic [MINSEC_W-1:0] v);
    bcd_t r;
    r.tens = 3'(v / 6'd10);
    r.ones = 4'(v % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/hour_display_mapper.sv
// rtl/hour_display_mapper.sv - binary hour to 24h/12h display digits and PM flag
module hour_display_mapper
  import clock_pkg::*;
(
  input  logic [HOUR_W-1:0] hour,
  input  logic              mode_24h,
  output logic [1:0]        hr_tens,
  output logic [3:0]        hr_ones,
  output logic              pm
);

  logic [HOUR_W-1:0] disp;

  always_comb begin
    pm   = (hour >= HOUR_W'(HALF_DAY));
    disp = hour;
    if (!mode_24h) begin
      // midnight and noon both display as 12
      disp = pm ? hour - HOUR_W'(HALF_DAY) : hour;
      if (disp == '0) disp = HOUR_W'(HALF_DAY);
    end
    hr_tens = 2'(disp / 5'd10);
    hr_ones = 4'(disp % 5'd10);
  end

endmodule

// File: rtl/time_of_day_counter.sv
// rtl/time_of_day_counter.sv - h/m/s timekeeping with set, increment and registered BCD display
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0,
  parameter int SHOW_SEC   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                mode_24h,
  input  logic                set_en,
  input  logic [HOUR_W-1:0]   set_hour,
  input  logic [MINSEC_W-1:0] set_min,
  input  logic                inc_hour,
  input  logic                inc_min,
  output logic [HOUR_W-1:0]   hour,
  output logic [MINSEC_W-1:0] minute,
  output logic [MINSEC_W-1:0] second,
  output logic [1:0]          hr_tens,
  output logic [3:0]          hr_ones,
  output logic [2:0]          min_tens,
  output logic [3:0]          min_ones,
  output logic [2:0]          sec_tens,
  output logic [3:0]          sec_ones,
  output logic                pm,
  output logic                day_pulse
);

  localparam logic [HOUR_W-1:0]   HOUR_MAX = HOUR_W'(HOURS_PER_DAY - 1);
  localparam logic [MINSEC_W-1:0] MIN_MAX  = MINSEC_W'(MIN_PER_HOUR - 1);
  localparam logic [MINSEC_W-1:0] SEC_MAX  = MINSEC_W'(SEC_PER_MIN - 1);
  localparam logic [HOUR_W-1:0]   RST_H    = HOUR_W'(RESET_HOUR);
  localparam logic [MINSEC_W-1:0] RST_M    = MINSEC_W'(RESET_MIN);

  logic [HOUR_W-1:0]   hour_d, hour_wrap;
  logic [MINSEC_W-1:0] minute_d, second_d, min_wrap, sec_wrap;
  logic                day_d, set_ok;

  assign hour_wrap = (hour == HOUR_MAX) ? '0 : hour + 1'b1;
  assign min_wrap  = (minute == MIN_MAX) ? '0 : minute + 1'b1;
  assign sec_wrap  = (second == SEC_MAX) ? '0 : second + 1'b1;
  assign set_ok    = (set_hour <= HOUR_MAX) && (set_min <= MIN_MAX);

  // set > increment > tick; a losing event is simply dropped
  always_comb begin
    hour_d   = hour;
    minute_d = minute;
    second_d = second;
    day_d    = 1'b0;
    if (set_en) begin
      if (set_ok) begin
        hour_d   = set_hour;
        minute_d = set_min;
        second_d = '0;
      end
    end else if (inc_hour || inc_min) begin
      if (inc_hour) hour_d = hour_wrap;
      if (inc_min) begin
        minute_d = min_wrap;
        second_d = '0;
      end
    end else if (tick) begin
      second_d = sec_wrap;
      if (second == SEC_MAX) begin
        minute_d = min_wrap;
        if (minute == MIN_MAX) begin
          hour_d = hour_wrap;
          day_d  = (hour == HOUR_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour      <= RST_H;
      minute    <= RST_M;
      second    <= '0;
      day_pulse <= 1'b0;
    end else begin
      hour      <= hour_d;
      minute    <= minute_d;
      second    <= second_d;
      day_pulse <= day_d;
    end
  end

  logic [1:0] map_tens, rst_tens;
  logic [3:0] map_ones, rst_ones;
  logic       map_pm, rst_pm;
  logic [2:0] sec_tens_q;
  logic [3:0] sec_ones_q;

  hour_display_mapper u_map (
    .hour     (hour),
    .mode_24h (mode_24h),
    .hr_tens  (map_tens),
    .hr_ones  (map_ones),
    .pm       (map_pm)
  );

  // constant-input copy gives the 12-hour reset image of the display registers
  hour_display_mapper u_reset_map (
    .hour     (RST_H),
    .mode_24h (1'b0),
    .hr_tens  (rst_tens),
    .hr_ones  (rst_ones),
    .pm       (rst_pm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_tens    <= rst_tens;
      hr_ones    <= rst_ones;
      pm         <= rst_pm;
      min_tens   <= bcd_split(RST_M).tens;
      min_ones   <= bcd_split(RST_M).ones;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
    end else begin
      hr_tens    <= map_tens;
      hr_ones    <= map_ones;
      pm         <= map_pm;
      min_tens   <= bcd_split(minute).tens;
      min_ones   <= bcd_split(minute).ones;
      sec_tens_q <= bcd_split(second).tens;
      sec_ones_q <= bcd_split(second).ones;
    end
  end

  assign sec_tens = (SHOW_SEC != 0) ? sec_tens_q : '0;
  assign sec_ones = (SHOW_SEC != 0) ? sec_ones_q : '0;

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb/tb_time_of_day_counter.sv - directed self-checking bench for time_of_day_counter
module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       rst_n, tick, mode_24h, set_en, inc_hour, inc_min;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic [1:0] hr_tens;
  logic [3:0] hr_ones, min_ones, sec_ones;
  logic [2:0] min_tens, sec_tens;
  logic       pm, day_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  time_of_day_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .mode_24h  (mode_24h),
    .set_en    (set_en),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .inc_hour  (inc_hour),
    .inc_min   (inc_min),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .hr_tens   (hr_tens),
    .hr_ones   (hr_ones),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .pm        (pm),
    .day_pulse (day_pulse)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m);
    set_en = 1'b1; set_hour = 5'(h); set_min = 6'(m);
    step();
    set_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hour"}, int'(hour), h);
    check({tag, ".minute"}, int'(minute), m);
    check({tag, ".second"}, int'(second), s);
  endtask

  task automatic check_disp(input string tag, input int ht, input int ho, input int mt, input int mo, input int p);
    check({tag, ".hr_tens"}, int'(hr_tens), ht);
    check({tag, ".hr_ones"}, int'(hr_ones), ho);
    check({tag, ".min_tens"}, int'(min_tens), mt);
    check({tag, ".min_ones"}, int'(min_ones), mo);
    check({tag, ".pm"}, int'(pm), p);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; mode_24h = 1'b0; set_en = 1'b0;
    inc_hour = 1'b0; inc_min = 1'b0; set_hour = '0; set_min = '0;
    #12;
    check_time("reset", 0, 0, 0);
    check_disp("reset", 1, 2, 0, 0, 0);
    check("reset.day_pulse", int'(day_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_time("post_reset", 0, 0, 0);

    // midnight rollover
    set_time(23, 59);
    check_time("set2359", 23, 59, 0);
    ticks(59);
    check_time("at235959", 23, 59, 59);
    check("pre_roll.day_pulse", int'(day_pulse), 0);
    ticks(1);
    check_time("rollover", 0, 0, 0);
    check("rollover.day_pulse", int'(day_pulse), 1);
    step();
    check("after_roll.day_pulse", int'(day_pulse), 0);
    check_disp("midnight12h", 1, 2, 0, 0, 0);

    // 24h vs 12h display of 13:05
    mode_24h = 1'b1;
    set_time(13, 5);
    step();
    check_disp("1305_24h", 1, 3, 0, 5, 1);
    mode_24h = 1'b0;
    step();
    check_disp("1305_12h", 0, 1, 0, 5, 1);

    // invalid set ignored, set beats tick
    set_time(7, 30);
    ticks(20);
    set_time(25, 10);
    check_time("bad_set", 7, 30, 20);
    check("bad_set.sec_tens", int'(sec_tens), 2);
    check("bad_set.sec_ones", int'(sec_ones), 0);
    tick = 1'b1;
    set_time(8, 0);
    tick = 1'b0;
    check_time("set_vs_tick", 8, 0, 0);

    // held set_en freezes time
    set_en = 1'b1; tick = 1'b1;
    step(); step();
    set_en = 1'b0; tick = 1'b0;
    check_time("freeze", 8, 0, 0);

    // combined increments beat tick, no carry, no day pulse
    set_time(11, 59);
    ticks(40);
    check_time("at115940", 11, 59, 40);
    inc_hour = 1'b1; inc_min = 1'b1; tick = 1'b1;
    step();
    inc_hour = 1'b0; inc_min = 1'b0; tick = 1'b0;
    check_time("inc_both", 12, 0, 0);
    check("inc_both.day_pulse", int'(day_pulse), 0);
    step();
    check_disp("noon12h", 1, 2, 0, 0, 1);

    // single increments wrap independently
    set_time(23, 59);
    ticks(3);
    inc_min = 1'b1; step(); inc_min = 1'b0;
    check_time("inc_min_wrap", 23, 0, 0);
    ticks(4);
    inc_hour = 1'b1; step(); inc_hour = 1'b0;
    check_time("inc_hour_wrap", 0, 0, 4);
    check("inc_hour.day_pulse", int'(day_pulse), 0);
    mode_24h = 1'b1;
    step();
    check_disp("0000_24h", 0, 0, 0, 0, 0);
    mode_24h = 1'b0;

    // asynchronous reset mid-count
    set_time(5, 17);
    ticks(33);
    check_time("at051733", 5, 17, 33);
    #2 rst_n = 1'b0;
    #1;
    check_time("async_rst", 0, 0, 0);
    check_disp("async_rst", 1, 2, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);
    check_time("resume", 0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Sequential timekeeping core for the alarm clock: keeps hours/minutes/seconds in binary from a 1 Hz enable pulse.
- Supports direct time set and button-style increments.
- Produces registered BCD display digits in either 24-hour or 12-hour (with PM flag) format, selectable at run time.
- Sits between the prescaler (tick source) and the display/alarm-compare logic; generalises the old combinational hour-to-12h decode into a configurable counting block.

Parameters:
- RESET_HOUR, 0, hour (0-23) loaded on reset.
- RESET_MIN, 0, minute (0-59) loaded on reset.
- SHOW_SEC, 1, when 0 the seconds counter is still kept but the sec_tens/sec_ones outputs are tied to 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle pulse, once per second
- mode_24h  in  1  1 = 24-hour display, 0 = 12-hour display
- set_en  in  1  load set_hour/set_min this cycle
- set_hour  in  5  binary hour for set, 0-23
- set_min  in  6  binary minute for set, 0-59
- inc_hour  in  1  one-cycle pulse, advance hour
- inc_min  in  1  one-cycle pulse, advance minute
- hour  out  5  binary hour 0-23
- minute  out  6  binary minute 0-59
- second  out  6  binary second 0-59
- hr_tens  out  2  display hour tens digit
- hr_ones  out  4  display hour ones digit
- min_tens  out  3  minute tens digit
- min_ones  out  4  minute ones digit
- sec_tens  out  3  second tens digit
- sec_ones  out  4  second ones digit
- pm  out  1  1 when hour >= 12; valid in both modes
- day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 via tick

Behaviour:
- Reset (async, rst_n=0):
  - hour=RESET_HOUR, minute=RESET_MIN, second=0, day_pulse=0.
  - Display registers hold the decode of the reset time in 12-hour form: RESET_HOUR=0 gives hr 1,2, pm=0.
- Per-cycle priority: set_en > inc_hour/inc_min > tick. A lower-priority event in the same cycle is dropped, not deferred.
- set_en:
  - Loads set_hour and set_min, clears second to 0.
  - If set_hour>23 or set_min>59, the whole set is ignored; all counters hold.
  - While set_en is held high, time is frozen.
- inc_hour: hour+1, wrapping 23->0. Minute and second are unaffected. No day_pulse.
- inc_min:
  - minute+1, wrapping 59->0, with no carry into hour; second is cleared to 0.
  - If inc_hour and inc_min are asserted together, both apply: hour+1 and minute+1 independently, second cleared.
- tick (no higher-priority event in the cycle):
  - second+1; at 59, second wraps to 0 and carries to minute.
  - Minute at 59 with carry wraps to 0 and carries to hour; hour 23 with carry wraps to 0.
  - day_pulse=1 for exactly the cycle after a 23:59:59 tick, else 0.
- Binary outputs are the counter registers, updated on the clock edge where the event is sampled.
- Display latency:
  - BCD digits and pm are registered one stage after the counters, so they reflect the new time 1 cycle after the binary outputs.
  - A mode_24h change is visible 1 cycle later.
- 24-hour mode: hr_tens/hr_ones = hour/10, hour%10 (00-23).
- 12-hour mode: display hour h12 = 12 if hour%12==0, else hour%12.
  - hr_tens = 1 for h12 10-12, else 0; hr_ones = h12%10.
  - Resulting mapping: 0->12 AM, 12->12 PM, 13->1 PM, 23->11 PM.
- Minutes and seconds are plain BCD split, identical in both modes.
- No leading-zero blanking; that is the display driver's job.

Decomposition:
- Shared package (clock_pkg):
  - HOURS_PER_DAY=24, MIN_PER_HOUR=60, SEC_PER_MIN=60, HALF_DAY=12.
  - Width constants HOUR_W=5 and MINSEC_W=6.
- Sub-module hour_display_mapper:
  - Combinational.
  - Inputs: hour and mode_24h. Outputs: hr_tens, hr_ones, pm.
  - Instantiated before the display register stage.
  - Reused by the alarm-setting path.
- Minute/second BCD split is a small function in the package.

Test Plan:
- Reset with defaults -> binary 0:00:00; one cycle later hr_tens=1, hr_ones=2, min digits 0/0, pm=0, day_pulse=0.
- Set 23:59, then pulse tick 59 times, then 1 more -> hour=0, minute=0, second=0, day_pulse high exactly one cycle, digits 12:00 AM (mode_24h=0).
- Set 13:05 with mode_24h=1 -> hr 1,3, pm=1; toggle mode_24h=0 -> one cycle later hr 0,1, min 0,5, pm=1.
- set_en with set_hour=25, set_min=10 from 07:30:20 -> counters hold 07:30:20. set_en and tick in the same cycle with valid 08:00 -> 08:00:00, tick ignored.
- At 11:59:40, assert inc_min and inc_hour together with tick -> 12:00:00, pm=1 next cycle, no day_pulse.
- Mid-count at 05:17:33, drop rst_n asynchronously (between clock edges) -> outputs return to reset values immediately without a clock edge; counting resumes correctly after release.
